// File: rtl/hazard_pkg.sv
// Shared types and decode helpers for the decode-stage hazard/stall sequencer.
package hazard_pkg;

    localparam int unsigned INST_W    = 32;
    localparam int unsigned REG_W     = 4;
    localparam int unsigned OPTYPE_HI = 31;
    localparam int unsigned OPTYPE_LO = 30;
    localparam int unsigned OPCODE_HI = 29;
    localparam int unsigned OPCODE_LO = 26;
    localparam int unsigned RC_HI     = 25;
    localparam int unsigned RC_LO     = 22;
    localparam int unsigned RA_HI     = 21;
    localparam int unsigned RA_LO     = 18;
    localparam int unsigned RB_HI     = 17;
    localparam int unsigned RB_LO     = 14;

    typedef enum logic [1:0] {
        OP_ALU_R = 2'b00,
        OP_ALU_I = 2'b01,
        OP_MEM   = 2'b10,
        OP_BR    = 2'b11
    } op_type_t;

    typedef enum logic {
        RUN  = 1'b0,
        KILL = 1'b1
    } state_t;

    typedef struct packed {
        logic rd_a;
        logic rd_b;
        logic rd_c;
        logic wr_c;
    } dec_t;

    // Register read/write usage of one instruction; is_load is opCode[0].
    function automatic dec_t decode_inst(input op_type_t op, input logic is_load);
        dec_t d;
        d = '0;
        case (op)
            OP_ALU_R: begin
                d.rd_a = 1'b1;
                d.rd_b = 1'b1;
                d.wr_c = 1'b1;
            end
            OP_ALU_I: begin
                d.rd_a = 1'b1;
                d.wr_c = 1'b1;
            end
            OP_MEM: begin
                d.rd_a = 1'b1;
                d.rd_c = ~is_load;
                d.wr_c = is_load;
            end
            default: begin
                d.rd_a = 1'b1;
            end
        endcase
        return d;
    endfunction

endpackage

// File: rtl/hazard_stall_ctrl_scoreboard.sv
// Per-register in-flight write counters with sticky underflow error.
module reg_scoreboard #(
    parameter int unsigned DEPTH = 3,
    parameter int unsigned NREGS = 16,
    parameter int unsigned CW    = 2,
    parameter int unsigned IW    = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      inc,
    input  logic [IW-1:0]             inc_idx,
    input  logic                      dec,
    input  logic [IW-1:0]             dec_idx,
    output logic [NREGS-1:0][CW-1:0]  cnt,
    output logic                      sb_err
);

    logic [NREGS-1:0][CW-1:0] cnt_nxt;
    logic                     err_nxt;

    // Simultaneous inc and dec of one register cancel; dec at zero saturates.
    always_comb begin
        cnt_nxt = cnt;
        for (int r = 0; r < int'(NREGS); r++) begin
            if (inc && (inc_idx == IW'(r)) && !(dec && (dec_idx == IW'(r)))) begin
                if (cnt[r] != CW'(DEPTH)) begin
                    cnt_nxt[r] = cnt[r] + CW'(1);
                end
            end else if (dec && (dec_idx == IW'(r)) && !(inc && (inc_idx == IW'(r)))) begin
                if (cnt[r] != '0) begin
                    cnt_nxt[r] = cnt[r] - CW'(1);
                end
            end
        end
        err_nxt = sb_err | (dec & (cnt[dec_idx] == '0));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            sb_err <= 1'b0;
        end else begin
            cnt    <= cnt_nxt;
            sb_err <= err_nxt;
        end
    end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Decode-stage RAW/capacity stall and branch-kill sequencer for the 5-stage pipeline.
// Optional HAZARD_STATS_EN adds saturating stall_cycles / kill_cycles counters.
module hazard_stall_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned DEPTH        = 3,
    parameter int unsigned NREGS        = 16,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid,
    input  logic [31:0] id_inst,
    input  logic        wb_we,
    input  logic [3:0]  wb_rd,
    input  logic        branch_taken,
    output logic        pc_en,
    output logic        if_id_en,
    output logic        id_ex_en,
    output logic        id_ex_bubble,
    output logic        stall,
    output logic        sb_err
`ifdef HAZARD_STATS_EN
    ,
    output logic [31:0] stall_cycles,
    output logic [31:0] kill_cycles
`endif
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned KW = 2;

    state_t                   state_q, state_d;
    logic [KW-1:0]            kill_q, kill_d;
    logic [NREGS-1:0][CW-1:0] cnt;
    dec_t                     dec;
    logic [REG_W-1:0]         rc, ra, rb;
    logic                     hazard, cap, issue;
    logic                     unused_bits;

    assign rc          = id_inst[RC_HI:RC_LO];
    assign ra          = id_inst[RA_HI:RA_LO];
    assign rb          = id_inst[RB_HI:RB_LO];
    assign dec         = decode_inst(op_type_t'(id_inst[OPTYPE_HI:OPTYPE_LO]), id_inst[OPCODE_LO]);
    assign unused_bits = ^{id_inst[OPCODE_HI:OPCODE_LO+1], id_inst[RB_LO-1:0]};

    // No WB bypass: any nonzero registered count on a source blocks issue.
    assign hazard = id_valid & ((dec.rd_a & (cnt[ra] != '0)) |
                                (dec.rd_b & (cnt[rb] != '0)) |
                                (dec.rd_c & (cnt[rc] != '0)));
    assign cap    = id_valid & dec.wr_c & (cnt[rc] == CW'(DEPTH));

    always_comb begin
        state_d      = state_q;
        kill_d       = kill_q;
        pc_en        = 1'b0;
        if_id_en     = 1'b0;
        id_ex_en     = 1'b1;
        id_ex_bubble = 1'b1;
        stall        = 1'b0;
        issue        = 1'b0;
        if (rst) begin
            state_d = RUN;
            kill_d  = '0;
        end else if (branch_taken) begin
            // Branch outranks stall: the decode instruction is killed, not held.
            state_d  = KILL;
            kill_d   = KW'(FLUSH_CYCLES - 1);
            pc_en    = 1'b1;
            if_id_en = 1'b1;
        end else if (state_q == KILL) begin
            pc_en    = 1'b1;
            if_id_en = 1'b1;
            if (kill_q == '0) begin
                state_d = RUN;
            end else begin
                kill_d = kill_q - KW'(1);
            end
        end else if (hazard | cap) begin
            stall = 1'b1;
        end else begin
            pc_en        = 1'b1;
            if_id_en     = 1'b1;
            id_ex_bubble = ~id_valid;
            issue        = id_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            kill_q  <= '0;
        end else begin
            state_q <= state_d;
            kill_q  <= kill_d;
        end
    end

    reg_scoreboard #(
        .DEPTH (DEPTH),
        .NREGS (NREGS),
        .CW    (CW),
        .IW    (REG_W)
    ) u_sb (
        .clk     (clk),
        .rst     (rst),
        .inc     (issue & dec.wr_c),
        .inc_idx (rc),
        .dec     (wb_we),
        .dec_idx (wb_rd),
        .cnt     (cnt),
        .sb_err  (sb_err)
    );

`ifdef HAZARD_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= '0;
            kill_cycles  <= '0;
        end else begin
            if (stall && (stall_cycles != '1)) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
            if (((state_q == KILL) || branch_taken) && (kill_cycles != '1)) begin
                kill_cycles <= kill_cycles + 32'd1;
            end
        end
    end
`endif

endmodule
